// File: rtl/pow2_approx_pipe.sv
// ============================================================================
// Module   : pow2_approx_pipe
// Purpose  : Three-stage elastic 2^x approximation for signed Q(INT_W).(FRAC_W)
//            input, with optional quadratic mantissa correction and saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pow2_approx_pipe #(
  parameter int INT_W   = 4,
  parameter int FRAC_W  = 12,
  parameter int CORR_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INT_W+FRAC_W-1:0] in_x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INT_W+FRAC_W-1:0] out_pow,
  output logic                    out_sat,
  output logic [INT_W+FRAC_W-1:0] out_x
);

  localparam int c_W = INT_W + FRAC_W;

  // Stage registers
  logic             r_v1, r_v2, r_v3;
  logic [c_W-1:0]   r_x1, r_x2, r_x3;
  logic             r_neg2, r_sat2;
  logic [INT_W-1:0] r_s2;
  logic [FRAC_W:0]  r_m2;
  logic [c_W-1:0]   r_pow3;
  logic             r_sat3;

  // Elastic control: a stage loads if it is empty or its successor loads
  logic w_ld1, w_ld2, w_ld3;
  assign w_ld3    = en & (out_ready | ~r_v3);
  assign w_ld2    = en & (~r_v2 | w_ld3);
  assign w_ld1    = en & (~r_v1 | w_ld2);
  assign in_ready = w_ld1;

  // Decompose S1 contents into floor integer part and fraction
  logic [INT_W-1:0]  w_i;
  logic [FRAC_W-1:0] w_f;
  logic              w_neg;
  logic [INT_W-1:0]  w_s;
  logic              w_sat;
  logic [FRAC_W:0]   w_m;

  assign w_i   = r_x1[c_W-1:FRAC_W];
  assign w_f   = r_x1[FRAC_W-1:0];
  assign w_neg = w_i[INT_W-1];
  // Most negative i wraps to 2^(INT_W-1), which reads correctly as unsigned
  assign w_s   = w_neg ? (~w_i + INT_W'(1)) : w_i;
  assign w_sat = ~w_neg & (32'(w_s) >= 32'(INT_W));

  generate
    if (CORR_EN != 0) begin : g_corr
      localparam int c_PW = 2*FRAC_W + 1;
      localparam logic [FRAC_W:0] c_ONE = {1'b1, {FRAC_W{1'b0}}};
      logic [FRAC_W:0] w_cmp;
      logic [c_PW-1:0] w_prod;
      logic [FRAC_W:0] w_p;
      assign w_cmp  = c_ONE - (FRAC_W+1)'(w_f);
      assign w_prod = c_PW'(w_f) * c_PW'(w_cmp);
      assign w_p    = (FRAC_W+1)'(w_prod >> FRAC_W);
      // 0.3125 = 1/4 + 1/16
      assign w_m    = {1'b1, w_f} - (w_p >> 2) - (w_p >> 4);
    end else begin : g_plain
      assign w_m = {1'b1, w_f};
    end
  endgenerate

  // Final shift from S2 contents
  logic [c_W-1:0] w_base;
  logic           w_zero;
  logic [c_W-1:0] w_pow;

  assign w_base = c_W'(r_m2);
  assign w_zero = r_neg2 & (32'(r_s2) >= 32'(FRAC_W + 1));

  always_comb begin
    w_pow = '0;
    if (r_sat2) begin
      w_pow = '1;
    end else if (r_neg2) begin
      if (!w_zero) w_pow = w_base >> r_s2;
    end else begin
      w_pow = w_base << r_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_x1   <= '0;
      r_x2   <= '0;
      r_x3   <= '0;
      r_neg2 <= 1'b0;
      r_sat2 <= 1'b0;
      r_s2   <= '0;
      r_m2   <= '0;
      r_pow3 <= '0;
      r_sat3 <= 1'b0;
    end else begin
      if (w_ld1) begin
        r_v1 <= in_valid;
        if (in_valid) r_x1 <= in_x;
      end
      if (w_ld2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_x2   <= r_x1;
          r_neg2 <= w_neg;
          r_sat2 <= w_sat;
          r_s2   <= w_s;
          r_m2   <= w_m;
        end
      end
      // Data only moves with a real beat so outputs stay put across bubbles
      if (w_ld3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_x3   <= r_x2;
          r_pow3 <= w_pow;
          r_sat3 <= r_sat2;
        end
      end
    end
  end

  assign out_valid = r_v3;
  assign out_pow   = r_pow3;
  assign out_sat   = r_sat3;
  assign out_x     = r_x3;

endmodule

`default_nettype wire

// File: tb/tb_pow2_approx_pipe.sv
// ============================================================================
// Module   : tb_pow2_approx_pipe
// Purpose  : Scoreboard bench for pow2_approx_pipe (Q4.12 plain and corrected,
//            Q5.10 corrected), all three instances sharing one handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pow2_approx_pipe;

  typedef struct packed {
    logic [15:0] xa; logic sa; logic [15:0] pa;
    logic [15:0] xb; logic sb; logic [15:0] pb;
    logic [14:0] xc; logic sc; logic [14:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, out_ready;
  logic [15:0] in_x;
  logic        rdy_a, rdy_b, rdy_c, va, vb, vc;
  logic [15:0] pow_a, pow_b, x_a, x_b;
  logic [14:0] pow_c, x_c;
  logic        sat_a, sat_b, sat_c;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic acc, drn;
  exp_t obs, e;
  exp_t sbq[$];

  always #5 clk = ~clk;

  pow2_approx_pipe #(.INT_W(4), .FRAC_W(12), .CORR_EN(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_a),
    .in_x(in_x), .out_valid(va), .out_ready(out_ready), .out_pow(pow_a),
    .out_sat(sat_a), .out_x(x_a));
  pow2_approx_pipe #(.INT_W(4), .FRAC_W(12), .CORR_EN(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_b),
    .in_x(in_x), .out_valid(vb), .out_ready(out_ready), .out_pow(pow_b),
    .out_sat(sat_b), .out_x(x_b));
  pow2_approx_pipe #(.INT_W(5), .FRAC_W(10), .CORR_EN(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_c),
    .in_x(in_x[14:0]), .out_valid(vc), .out_ready(out_ready), .out_pow(pow_c),
    .out_sat(sat_c), .out_x(x_c));

  // Reference 2^x in plain integer arithmetic; returns {sat, pow}
  function automatic logic [16:0] model(input int iw, input int fw, input int corr,
                                        input logic [15:0] xin);
    longint w, xs, i, f, m, p, pw;
    logic   sat;
    w  = iw + fw;
    xs = longint'(xin) & ((longint'(1) << w) - 1);
    if (xs >= (longint'(1) << (w - 1))) xs = xs - (longint'(1) << w);
    i  = xs >>> fw;
    f  = xs & ((longint'(1) << fw) - 1);
    m  = (longint'(1) << fw) + f;
    if (corr != 0) begin
      p = (f * ((longint'(1) << fw) - f)) >> fw;
      m = m - (p >> 2) - (p >> 4);
    end
    sat = 1'b0;
    if (i >= iw) begin
      pw  = (longint'(1) << w) - 1;
      sat = 1'b1;
    end else if (i >= 0) begin
      pw = m << i;
    end else if (-i >= fw + 1) begin
      pw = 0;
    end else begin
      pw = m >> (-i);
    end
    return {sat, pw[15:0]};
  endfunction

  function automatic exp_t exp_of(input logic [15:0] x);
    logic [16:0] a, b, c;
    exp_t r;
    a = model(4, 12, 0, x);
    b = model(4, 12, 1, x);
    c = model(5, 10, 1, {1'b0, x[14:0]});
    r.xa = x;       r.sa = a[16]; r.pa = a[15:0];
    r.xb = x;       r.sb = b[16]; r.pb = b[15:0];
    r.xc = x[14:0]; r.sc = c[16]; r.pc = c[14:0];
    return r;
  endfunction

  // One clock: handshake flags and outputs sampled mid-cycle, returns #1 after edge
  task automatic cycle();
    @(negedge clk);
    acc = in_valid && rdy_a && !rst;
    drn = en && va && out_ready && !rst;
    obs.xa = x_a; obs.sa = sat_a; obs.pa = pow_a;
    obs.xb = x_b; obs.sb = sat_b; obs.pb = pow_b;
    obs.xc = x_c; obs.sc = sat_c; obs.pc = pow_c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0;
    repeat (3) cycle();
    rst = 1'b0;
    n_tests++;
    if ({va, vb, vc} !== 3'b000 || {pow_a, pow_b, pow_c} !== '0 ||
        {sat_a, sat_b, sat_c} !== 3'b000 || {x_a, x_b, x_c} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b pow=%h/%h/%h sat=%b%b%b x=%h/%h/%h, required all zero",
               {va, vb, vc}, pow_a, pow_b, pow_c, sat_a, sat_b, sat_c, x_a, x_b, x_c);
    end
    n_tests++;
    if (rdy_a !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready_en1: got %b, required 1", rdy_a);
    end
    en = 1'b0; #1;
    n_tests++;
    if (rdy_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready_en0: got %b, required 0", rdy_a);
    end
    en = 1'b1;
  endtask

  task automatic test_points();
    logic [15:0] px[8], pa[8], pb[8];
    logic        ps[8];
    int          lat;
    px = '{16'h0000, 16'h1000, 16'hF000, 16'h8000, 16'h0800, 16'h3800, 16'h4000, 16'h7FFF};
    pa = '{16'h1000, 16'h2000, 16'h0800, 16'h0010, 16'h1800, 16'hC000, 16'hFFFF, 16'hFFFF};
    pb = '{16'h1000, 16'h2000, 16'h0800, 16'h0010, 16'h16C0, 16'hB600, 16'hFFFF, 16'hFFFF};
    ps = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_x = px[k]; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      n_tests++;
      if (!acc) begin
        n_fail++; $display("FAIL point_accept x=%h: got 0, required 1", px[k]);
      end
      e = exp_of(px[k]);
      e.pa = pa[k]; e.sa = ps[k]; e.pb = pb[k]; e.sb = ps[k];
      if (acc) sbq.push_back(e);
      lat = 0;
      do begin cycle(); lat++; end while (!drn && lat < 10);
      n_tests++;
      if (lat != 3) begin
        n_fail++; $display("FAIL point_latency x=%h: got %0d, required 3", px[k], lat);
      end
      if (drn) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL point_extra: got %h, required no beat", obs);
        end else begin
          e = sbq.pop_front();
          if (obs !== e) begin
            n_fail++; $display("FAIL point_value x=%h: got %h, required %h", px[k], obs, e);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] bx[6];
    int          sent, drains;
    for (int k = 0; k < 6; k++) bx[k] = 16'($urandom);
    out_ready = 1'b0; in_valid = 1'b1; sent = 0; drains = 0;
    for (int k = 0; k < 5; k++) begin
      in_x = bx[sent];
      cycle();
      if (acc) begin sbq.push_back(exp_of(in_x)); sent++; end
    end
    n_tests++;
    if (sent != 3 || rdy_a !== 1'b0) begin
      n_fail++; $display("FAIL bp_fill: accepted %0d in_ready=%b, required 3 and 0", sent, rdy_a);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = (sent < 5);
      in_x = bx[sent];
      cycle();
      if (drn) begin
        drains++;
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL bp_extra: got %h, required no beat", obs);
        end else begin
          e = sbq.pop_front();
          if (obs !== e) begin
            n_fail++; $display("FAIL bp_value: got %h, required %h", obs, e);
          end
        end
      end
      if (acc) begin sbq.push_back(exp_of(in_x)); sent++; end
    end
    in_valid = 1'b0;
    n_tests++;
    if (drains != 5 || sent != 5) begin
      n_fail++; $display("FAIL bp_drain: drained %0d sent %0d in 5 cycles, required 5 and 5", drains, sent);
    end
  endtask

  task automatic test_freeze();
    exp_t snap;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_x = 16'($urandom);
      cycle();
      if (drn) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL frz_extra: got %h, required no beat", obs);
        end else begin
          e = sbq.pop_front();
          if (obs !== e) begin
            n_fail++; $display("FAIL frz_value: got %h, required %h", obs, e);
          end
        end
      end
      if (acc) sbq.push_back(exp_of(in_x));
    end
    snap.xa = x_a; snap.sa = sat_a; snap.pa = pow_a;
    snap.xb = x_b; snap.sb = sat_b; snap.pb = pow_b;
    snap.xc = x_c; snap.sc = sat_c; snap.pc = pow_c;
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_x = 16'($urandom);
      cycle();
      n_tests++;
      if (acc || va !== 1'b1 || rdy_a !== 1'b0 || obs !== snap) begin
        n_fail++;
        $display("FAIL frz_hold: acc=%b valid=%b ready=%b out=%h, required 0 1 0 %h",
                 acc, va, rdy_a, obs, snap);
      end
    end
    en = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (drn) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL frz_extra: got %h, required no beat", obs);
        end else begin
          e = sbq.pop_front();
          if (obs !== e) begin
            n_fail++; $display("FAIL frz_value: got %h, required %h", obs, e);
          end
        end
      end
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL frz_lost: %0d beats pending, required 0", sbq.size());
    end
  endtask

  task automatic test_rst_inflight();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_x = 16'($urandom);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_tests++;
    if ({va, vb, vc} !== 3'b000 || {pow_a, pow_b, pow_c} !== '0 ||
        {sat_a, sat_b, sat_c} !== 3'b000 || {x_a, x_b, x_c} !== '0) begin
      n_fail++;
      $display("FAIL rst_flush: valid=%b pow=%h/%h/%h x=%h/%h/%h, required all zero",
               {va, vb, vc}, pow_a, pow_b, pow_c, x_a, x_b, x_c);
    end
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_tests++;
      if (drn) begin
        n_fail++; $display("FAIL rst_ghost: got beat %h, required none", obs);
      end
    end
  endtask

  task automatic test_random();
    int sent, cyc;
    sent = 0; cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 9) < 8);
      in_x      = 16'($urandom);
      cycle();
      cyc++;
      if (drn) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra: got %h, required no beat", obs);
        end else begin
          e = sbq.pop_front();
          if (obs !== e) begin
            n_fail++; $display("FAIL rnd_value: got %h, required %h", obs, e);
          end
        end
      end
      if (acc) begin sbq.push_back(exp_of(in_x)); sent++; end
    end
    n_tests++;
    if (sent != 10000) begin
      n_fail++; $display("FAIL rnd_budget: sent %0d, required 10000", sent);
    end
    en = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (drn) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra: got %h, required no beat", obs);
        end else begin
          e = sbq.pop_front();
          if (obs !== e) begin
            n_fail++; $display("FAIL rnd_value: got %h, required %h", obs, e);
          end
        end
      end
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL rnd_lost: %0d beats pending, required 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_points();
    test_backpressure();
    test_freeze();
    test_rst_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
